// File: rtl/pc_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit_pkg
//   Shared definitions for the fetch stage:
//     - XLEN               : datapath / instruction word width
//     - PC_STEP_DEFAULT    : default sequential PC increment (bytes)
//     - fetch_state_e      : fetch FSM state encoding
//     - is_word_aligned()  : true when an address has bits [1:0] == 0
// -----------------------------------------------------------------------------
package pc_fetch_unit_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned PC_STEP_DEFAULT = 4;

  // Explicit encoding so that waveforms and any external debug taps stay stable.
  typedef enum logic [1:0] {
    FETCH = 2'b00,
    ISSUE = 2'b01,
    TRAP  = 2'b10
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage : pc_fetch_unit_pkg

// File: rtl/pc_fetch_unit_pc_register.sv
// -----------------------------------------------------------------------------
// pc_register
//   Program-counter storage: a single XLEN-bit register with asynchronous
//   active-high reset to RESET_PC and a synchronous load enable.
//
//   Ports:
//     clock   in   rising-edge clock
//     reset   in   asynchronous active-high reset (forces RESET_PC)
//     load_i  in   1 = capture pc_d_i on the next rising edge
//     pc_d_i  in   next program counter value
//     pc_o    out  current program counter
// -----------------------------------------------------------------------------
module pc_register
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_i,
  input  logic [XLEN-1:0] pc_d_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= pc_d_i;
    end
  end

  assign pc_o = pc_q;

endmodule : pc_register

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Instruction fetch stage. Requests the word at PC, captures it when the
//   instruction memory acknowledges, presents the instr/PC pair to decode and
//   advances PC to the externally selected PCNext once decode releases it.
//   A misaligned PCNext parks the unit in TRAP until reset.
//
//   Parameters:
//     RESET_PC   PC loaded on reset (must be word aligned)
//     PC_STEP    sequential increment used to form PCPlus4
//
//   Ports:
//     clock       in   rising-edge clock
//     reset       in   asynchronous active-high reset
//     PCNext      in   next PC from the branch-select multiplexer
//     stall       in   1 = decode holds the current instruction
//     imemAck     in   instruction memory returns data this cycle
//     imemData    in   instruction word (valid while imemAck=1)
//     imemReq     out  fetch request
//     imemAddr    out  fetch address (== PC)
//     PC          out  current program counter
//     PCPlus4     out  PC + PC_STEP (mod 2^32)
//     instr       out  captured instruction word
//     instrValid  out  instr/PC pair valid for decode
//     misaligned  out  sticky: a misaligned PCNext was loaded
//     fetchCount  out  number of instructions released to decode (wraps)
// -----------------------------------------------------------------------------
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] PCNext,
  input  logic            stall,
  input  logic            imemAck,
  input  logic [XLEN-1:0] imemData,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic [XLEN-1:0] instr,
  output logic            instrValid,
  output logic            misaligned,
  output logic [XLEN-1:0] fetchCount
);

  // Refuse to elaborate with a reset vector that could never be fetched.
  if (!is_word_aligned(RESET_PC)) begin : g_reset_pc_misaligned
    $error("pc_fetch_unit: RESET_PC must be a multiple of 4");
  end

  localparam logic [XLEN-1:0] PC_STEP_W = XLEN'(PC_STEP);

  fetch_state_e    state_q;
  logic [XLEN-1:0] instr_q;
  logic            instr_valid_q;
  logic [XLEN-1:0] fetch_count_q;
  logic [XLEN-1:0] fetch_count_d;
  logic            misaligned_q;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            pc_load;

  // PC advances only when decode releases the instruction held in ISSUE.
  always_comb begin
    pc_load       = (state_q == ISSUE) && !stall;
    pc_d          = PCNext;
    fetch_count_d = fetch_count_q + {{(XLEN-1){1'b0}}, 1'b1};
  end

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clock  (clock),
    .reset  (reset),
    .load_i (pc_load),
    .pc_d_i (pc_d),
    .pc_o   (pc_q)
  );

  // Fetch FSM together with its registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fetch_count_q <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          // Memory may take any number of cycles; PC is held meanwhile.
          if (imemAck) begin
            instr_q       <= imemData;
            instr_valid_q <= 1'b1;
            state_q       <= ISSUE;
          end
        end

        ISSUE: begin
          if (!stall) begin
            instr_valid_q <= 1'b0;
            fetch_count_q <= fetch_count_d;
            if (is_word_aligned(PCNext)) begin
              state_q <= FETCH;
            end else begin
              // The faulting address is still loaded into PC so software
              // can read it; the fault flag is raised together with it.
              misaligned_q <= 1'b1;
              state_q      <= TRAP;
            end
          end
        end

        TRAP: begin
          // Terminal state: only reset leaves it.
          misaligned_q  <= 1'b1;
          instr_valid_q <= 1'b0;
        end

        default: begin
          // Unreachable encoding; recover to a clean fetch.
          instr_valid_q <= 1'b0;
          state_q       <= FETCH;
        end
      endcase
    end
  end

  // Request is gated by reset directly so a reset mid-fetch drops it at once.
  assign imemReq    = (state_q == FETCH) && !reset;
  assign imemAddr   = pc_q;
  assign PC         = pc_q;
  assign PCPlus4    = pc_q + PC_STEP_W;
  assign instr      = instr_q;
  assign instrValid = instr_valid_q;
  assign misaligned = misaligned_q;
  assign fetchCount = fetch_count_q;

endmodule : pc_fetch_unit

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset; SHALL be a multiple of 4, with elaboration failing otherwise.
REQ-002 Parameter PC_STEP, default 4, sequential increment used for PCPlus4.
REQ-003 One clock; reset is asynchronous and active-high. The ports are named `clock` and `reset`.
REQ-004 clock       input   1   rising-edge clock.
REQ-005 reset       input   1   asynchronous, active-high reset.
REQ-006 PCNext      input   32  next PC from the branch-select multiplexer.
REQ-007 stall       input   1   decode/hazard hold; 1 = keep current instruction.
REQ-008 imemAck     input   1   instruction memory has data for the current request.
REQ-009 imemData    input   32  instruction word; valid only while imemAck=1.
REQ-010 imemReq     output  1   fetch request.
REQ-011 imemAddr    output  32  fetch address, equal to PC.
REQ-012 PC          output  32  current program counter.
REQ-013 PCPlus4     output  32  PC+PC_STEP, fed to the sequential adder path of the next-PC mux.
REQ-014 instr       output  32  captured instruction word.
REQ-015 instrValid  output  1   instr/PC pair valid for decode.
REQ-016 misaligned  output  1   sticky fault: a PCNext with bits[1:0]!=0 was loaded.
REQ-017 fetchCount  output  32  count of instructions released to decode.

Function
REQ-018 FSM states SHALL be FETCH, ISSUE and TRAP; the reset state SHALL be FETCH.
REQ-019 imemReq SHALL equal (state==FETCH) & ~reset, and imemAddr SHALL equal PC combinationally.
REQ-020 In FETCH, while imemAck=0, the unit SHALL hold PC and imemAddr stable and keep imemReq=1.
REQ-021 In FETCH with imemAck=1 at edge n, the unit SHALL set instr=imemData and instrValid=1 from n+1, and state SHALL become ISSUE.
REQ-022 In ISSUE with stall=1, the unit SHALL hold state, PC, instr, instrValid and fetchCount.
REQ-023 In ISSUE with stall=0 at edge m, the unit SHALL load PC=PCNext, set instrValid=0, increment fetchCount, and enter FETCH (PCNext[1:0]==0) or TRAP (otherwise).
REQ-024 In TRAP, the unit SHALL set misaligned=1, hold imemReq=0, instrValid=0, PC=faulting PCNext and fetchCount, and leave TRAP only on reset.
REQ-025 Best-case throughput SHALL be one instruction per 2 cycles (ack in the same cycle as the request).
REQ-026 imemAck and imemData SHALL be ignored outside FETCH.
REQ-027 PCPlus4 SHALL be computed modulo 2^32, so PC=32'hFFFFFFFC gives PCPlus4=0.
REQ-028 fetchCount SHALL wrap from 32'hFFFFFFFF to 0.
REQ-029 PC SHALL change only on an ISSUE->FETCH/TRAP transition or on reset.

Reset
REQ-030 While reset=1, outputs SHALL be: PC=RESET_PC, PCPlus4=RESET_PC+PC_STEP, instr=0, instrValid=0, misaligned=0, fetchCount=0, imemReq=0.
REQ-031 Reset asserted mid-fetch SHALL abandon the request immediately (imemReq=0 asynchronously), and any later ack for it is not expected.
REQ-032 On the first rising edge after reset deasserts, state SHALL be FETCH with imemReq=1 and imemAddr=RESET_PC.

Structure
REQ-033 A shared package SHALL hold the state encoding (FETCH=2'b00, ISSUE=2'b01, TRAP=2'b10), the PC_STEP default and the 32-bit word width constant.
REQ-034 The PC storage SHALL be one sub-module, pc_register: a 32-bit register with async reset to RESET_PC and a load enable.
REQ-035 The instr, instrValid, fetchCount and misaligned registers and the FSM SHALL stay in pc_fetch_unit.

Verification
REQ-036 Reset release, imemAck=1 every FETCH cycle, stall=0, PCNext=PCPlus4 -> imemAddr sequence 0,4,8,12 on alternate cycles, and fetchCount=4 after 8 cycles.
REQ-037 imemAck held 0 for 5 cycles at PC=8 -> imemReq=1 and imemAddr=8 stable throughout; instrValid rises the cycle after ack, with instr=imemData.
REQ-038 stall=1 for 3 cycles in ISSUE with instr=32'h00A00093 -> instr, PC and instrValid unchanged; PC takes PCNext=32'h40 on the first edge after stall=0.
REQ-039 PCNext=32'h42 on release -> PC=32'h42, misaligned=1, imemReq=0 permanently, with later acks ignored until reset.
REQ-040 reset pulsed mid-FETCH at PC=32'h100 -> imemReq=0 immediately; after release PC=RESET_PC and fetchCount=0.
REQ-041 PC preloaded to 32'hFFFFFFFC -> PCPlus4=0, and after issue with PCNext=PCPlus4, imemAddr=0.
